// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter sharing one 32-bit memory port between four
//   requesters (0 = instruction fetch, 1 = load/store, 2..3 = spare).
//   Drives the select of the external 4:1 address/wdata/control muxes and
//   sequences each transaction: grant, valid/ready handshake, per-requester
//   acknowledge and bus-timeout abort.
//
//   Parameters:
//     TIMEOUT      max cycles mem_valid_o stays high before abort (2..256)
//   Ports:
//     clk_i        clock, rising edge
//     rst_n_i      synchronous active-low reset
//     req_i[3:0]   per-requester request, held until that requester's ack
//     mem_ready_i  shared port completes the current transaction this cycle
//     sel_o[1:0]   index of the granted requester (external mux select)
//     grant_o[3:0] one-hot grant, zero when idle
//     mem_valid_o  transaction presented on the shared port
//     ack_o[3:0]   one-cycle completion pulse to the grantee
//     err_o        qualifies ack_o: transaction aborted by timeout
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] req_i,
    input  logic       mem_ready_i,
    output logic [1:0] sel_o,
    output logic [3:0] grant_o,
    output logic       mem_valid_o,
    output logic [3:0] ack_o,
    output logic       err_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q,   sel_d;
    logic [1:0] last_q,  last_d;
    logic [7:0] cnt_q,   cnt_d;

    logic       timeout;
    logic       end_of_txn;
    logic [3:0] arb_req;
    logic       pick_found;
    logic [1:0] pick_idx;
    logic [1:0] cand;

    assign timeout    = (cnt_q == 8'(TIMEOUT - 1));
    assign end_of_txn = (state_q == BUSY) && (mem_ready_i || timeout);

    // At end of transaction the current grantee is masked so it cannot be
    // re-granted back-to-back even if it still holds its request.
    assign arb_req = (state_q == IDLE) ? req_i : (req_i & ~grant_q);

    // Search order last+1, last+2, last+3, last (mod 4).
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_q;
        cand       = last_q;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!pick_found && arb_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    grant_d = 4'b0001 << pick_idx;
                    sel_d   = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (end_of_txn) begin
                    cnt_d = '0;
                    if (pick_found) begin
                        grant_d = 4'b0001 << pick_idx;
                        sel_d   = pick_idx;
                        last_d  = pick_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs; ready wins over a coincident timeout
    always_comb begin
        sel_o       = sel_q;
        grant_o     = grant_q;
        mem_valid_o = (state_q == BUSY);
        ack_o       = '0;
        err_o       = 1'b0;
        if (end_of_txn) begin
            ack_o = grant_q;
            err_o = !mem_ready_i;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       ready;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic [3:0] ack;
    logic       err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .req_i      (req),
        .mem_ready_i(ready),
        .sel_o      (sel),
        .grant_o    (grant),
        .mem_valid_o(valid),
        .ack_o      (ack),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive inputs for the current cycle and let combinational outputs settle
    task automatic drive(input logic r, input logic [3:0] q, input logic rd);
        rst_n = r;
        req   = q;
        ready = rd;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 4'b0000, 1'b0);
        step();
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        ready = 1'b0;

        // Reset state
        do_reset();
        drive(1'b0, 4'b0000, 1'b0);
        chk("rst_grant", 8'(grant), 8'h0);
        chk("rst_sel",   8'(sel),   8'h0);
        chk("rst_valid", 8'(valid), 8'h0);
        chk("rst_ack",   8'(ack),   8'h0);
        chk("rst_err",   8'(err),   8'h0);
        step();

        // Single request from load/store
        drive(1'b1, 4'b0010, 1'b0);
        chk("single_idle_grant", 8'(grant), 8'h0);
        step();
        drive(1'b1, 4'b0010, 1'b0);
        chk("single_c3_grant", 8'(grant), 8'h2);
        chk("single_c3_sel",   8'(sel),   8'h1);
        chk("single_c3_valid", 8'(valid), 8'h1);
        chk("single_c3_ack",   8'(ack),   8'h0);
        step();
        drive(1'b1, 4'b0010, 1'b0);
        chk("single_c4_grant", 8'(grant), 8'h2);
        step();
        drive(1'b1, 4'b0010, 1'b1);
        chk("single_c5_ack", 8'(ack), 8'h2);
        chk("single_c5_err", 8'(err), 8'h0);
        chk("single_c5_sel", 8'(sel), 8'h1);
        step();
        drive(1'b1, 4'b0000, 1'b0);
        chk("single_c6_grant", 8'(grant), 8'h0);
        chk("single_c6_valid", 8'(valid), 8'h0);
        chk("single_c6_ack",   8'(ack),   8'h0);
        step();

        // Fairness: all requesting, ready always
        do_reset();
        drive(1'b1, 4'b1111, 1'b1);
        chk("fair_idle_valid", 8'(valid), 8'h0);
        step();
        for (int i = 0; i < 5; i++) begin
            logic [1:0] exp_sel;
            exp_sel = 2'(i % 4);
            drive(1'b1, 4'b1111, 1'b1);
            chk("fair_sel",   8'(sel),   8'(exp_sel));
            chk("fair_valid", 8'(valid), 8'h1);
            chk("fair_ack",   8'(ack),   8'(4'b0001 << exp_sel));
            step();
        end

        // Starvation: requesters 0 and 1 alternate
        do_reset();
        drive(1'b1, 4'b0011, 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'b0011, 1'b1);
            chk("starve_grant", 8'(grant), (i % 2 == 0) ? 8'h1 : 8'h2);
            step();
        end

        // Timeout with TIMEOUT=4
        do_reset();
        drive(1'b1, 4'b0100, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'b0100, 1'b0);
            chk("tmo_valid", 8'(valid), 8'h1);
            chk("tmo_ack",   8'(ack),   (i == 3) ? 8'h4 : 8'h0);
            chk("tmo_err",   8'(err),   (i == 3) ? 8'h1 : 8'h0);
            step();
        end
        drive(1'b1, 4'b0000, 1'b0);
        chk("tmo_after_valid", 8'(valid), 8'h0);
        chk("tmo_after_grant", 8'(grant), 8'h0);
        step();

        // Ready coinciding with timeout
        drive(1'b1, 4'b0100, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'b0100, (i == 3));
            chk("coll_ack", 8'(ack), (i == 3) ? 8'h4 : 8'h0);
            chk("coll_err", 8'(err), 8'h0);
            step();
        end
        drive(1'b1, 4'b0000, 1'b0);
        chk("coll_after_valid", 8'(valid), 8'h0);
        step();

        // Reset mid-transaction (requester 2 takes last=2 first)
        drive(1'b1, 4'b0100, 1'b0);
        step();
        drive(1'b1, 4'b0100, 1'b0);
        chk("midrst_b1_grant", 8'(grant), 8'h4);
        step();
        drive(1'b0, 4'b0100, 1'b0);
        chk("midrst_b2_ack", 8'(ack), 8'h0);
        step();
        drive(1'b1, 4'b1001, 1'b0);
        chk("midrst_grant", 8'(grant), 8'h0);
        chk("midrst_valid", 8'(valid), 8'h0);
        chk("midrst_ack",   8'(ack),   8'h0);
        chk("midrst_err",   8'(err),   8'h0);
        step();
        drive(1'b1, 4'b1001, 1'b0);
        chk("midrst_regrant", 8'(grant), 8'h1);
        chk("midrst_sel",     8'(sel),   8'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound on total simulation time
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares one 32-bit memory port between four requesters. Requester 0 is instruction fetch, requester 1 is load/store, and requesters 2–3 are spare ports. The block drives the 2-bit select of the external 4:1 32-bit muxes that steer address, write data and control onto the shared port. It also sequences each transaction: grant, valid/ready handshake, per-requester acknowledge, and a bus-timeout abort.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles mem_valid_o stays high for one transaction before abort; legal range 2..256.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_n_i  in  1  reset; synchronous, active-low.
- req_i  in  4  per-requester request; held high until that requester's ack_o bit.
- mem_ready_i  in  1  memory port completes the current transaction this cycle.
- sel_o  out  2  select for the external address/wdata/control 4:1 muxes; index of the granted requester.
- grant_o  out  4  one-hot grant; all zero when idle.
- mem_valid_o  out  1  transaction presented on the shared port.
- ack_o  out  4  one-cycle completion pulse to the granted requester.
- err_o  out  1  qualifies ack_o: 1 means the transaction was aborted by timeout.

## Operation
- States: IDLE (grant_o=0, mem_valid_o=0) and BUSY (exactly one grant_o bit set, mem_valid_o=1).
- Round-robin pointer `last` (2 bits) holds the most recently granted index.
  - Search order: last+1, last+2, last+3, last (mod 4).
  - Reset sets `last`=3, so requester 0 has top priority after reset.
- IDLE with any req_i bit set: arbitrate over all four bits, then register grant_o, sel_o, `last`, mem_valid_o=1, cnt=0, and go to BUSY.
- BUSY: sel_o and grant_o are frozen. Deassertion of req_i by the granted requester is ignored; the transaction runs to completion.
- Completion (BUSY, mem_ready_i=1):
  - ack_o[sel_o]=1 and err_o=0, combinationally in the same cycle.
- Timeout (BUSY, mem_ready_i=0, cnt==TIMEOUT-1):
  - ack_o[sel_o]=1 and err_o=1 in that cycle.
  - If mem_ready_i and timeout coincide, ready wins and err_o=0.
- End of transaction (completion or timeout):
  - Re-arbitrate at the same edge over req_i with the current grantee's bit masked, using the search order above.
  - If a winner exists, stay in BUSY with the new grant, `last` updated and cnt=0 (back-to-back, no idle cycle). Otherwise go to IDLE with grant_o=0.
- cnt (8 bits) increments each BUSY cycle without end of transaction. It never wraps, because an abort always occurs at TIMEOUT-1.
- ack_o and err_o are zero whenever mem_valid_o=0.

## Timing
- Reset values (rst_n_i=0 at an edge): grant_o=0, sel_o=2'b00, mem_valid_o=0, `last`=3, cnt=0, state IDLE. ack_o=0 and err_o=0 follow from mem_valid_o=0.
- Reset takes priority over every other event. Reset mid-transaction drops the grant with no ack_o pulse.
- Grant latency: req_i high in IDLE at cycle n gives grant_o/sel_o/mem_valid_o high at cycle n+1.
- Minimum transaction: mem_ready_i high in the first BUSY cycle, giving one cycle of mem_valid_o.
- Back-to-back: the next grant is visible in the cycle after the ack, so mem_valid_o stays continuously high.
- Timeout: mem_valid_o is high for exactly TIMEOUT cycles; err_o and ack_o pulse in the last of them.
- ack_o is a one-cycle pulse per transaction, never two consecutive cycles to the same requester unless it was re-granted.

## Test plan
- Single request: reset, then req_i=4'b0010 at cycle 2, mem_ready_i=1 at cycle 5 -> grant_o=0010 and sel_o=01 over cycles 3–5; ack_o=0010 at cycle 5; idle at cycle 6.
- Fairness: req_i=4'b1111 held, mem_ready_i=1 every cycle after reset -> sel_o sequence 0,1,2,3,0 on consecutive cycles with mem_valid_o continuously high.
- Starvation check: req_i[0] and req_i[1] held, ready every cycle -> grants alternate 0,1,0,1; requester 0 is never granted twice in a row.
- Timeout: TIMEOUT=4, req_i=4'b0100, mem_ready_i=0 -> mem_valid_o high for 4 cycles; ack_o=0100 and err_o=1 in the 4th; then IDLE.
- Ready/timeout collision: TIMEOUT=4, mem_ready_i=1 in the 4th BUSY cycle -> ack_o pulses with err_o=0.
- Reset mid-transaction: rst_n_i=0 in the 2nd BUSY cycle -> next cycle all outputs zero and no ack_o; after release, req_i=4'b1000|4'b0001 grants requester 0 first.
